fcmp_unit: RTL and testbench
============================

FCMP_UNIT -- requirements
Module: fcmp_unit

Interface
REQ-001 SHALL have parameter LEN_TAG, default 5, destination-register tag width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit accepts request this cycle.
REQ-006 SHALL have port func3  input  LEN_FUNC3  operation select (FEQ, FLT, FLE; FMIN, FMAX when configured).
REQ-007 SHALL have ports rs1 and rs2  input  LEN_WORD each  single-precision operands.
REQ-008 SHALL have port tag_in  input  LEN_TAG  destination register, carried unchanged.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  LEN_WORD  compare result zero-extended to 0/1, or min/max value.
REQ-012 SHALL have port tag_out  output  LEN_TAG  tag of the result.
REQ-013 SHALL have port illegal  output  1  func3 was unsupported, qualified by out_valid.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 registers the accepted request; S2 registers the computed result.
REQ-015 SHALL transfer a request when in_valid && in_ready, and a result when out_valid && out_ready.
REQ-016 SHALL have latency exactly 2 cycles from input transfer to out_valid with no back-pressure, sustaining 1 request/cycle.
REQ-017 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready (S1 advances when S2 empties or drains this cycle).
REQ-018 SHALL hold S2 contents stable while out_valid && !out_ready; S1 SHALL then hold too, and in_ready SHALL be 0 if S1 is full.
REQ-019 SHALL accept input, advance S1->S2 and drain S2 in the same cycle when all are enabled, with no bubble.
REQ-020 SHALL treat +0 and -0 as equal for FEQ, FLT and FLE: -0 < +0 is false and -0 <= +0 is true.
REQ-021 SHALL return 0 for FEQ, FLT and FLE when either operand is NaN (exponent 255, mantissa non-zero).
REQ-022 SHALL order non-NaN operands by sign, then exponent, then mantissa, with the magnitude order inverted when both are negative.
REQ-023 SHALL give FLE = FLT || FEQ.
REQ-024 SHALL drive result = 0 and illegal = 1 for an unsupported func3, and SHALL still produce the response with normal latency.

Reset
REQ-025 SHALL clear the S1 and S2 valid bits immediately on rstn low, regardless of clock.
REQ-026 SHALL reset out_valid = 0, result = 0, tag_out = 0 and illegal = 0, with in_ready = 1 while in reset.
REQ-027 SHALL discard any request in flight when reset is asserted mid-operation, and SHALL emit no result for it after release.

Configuration
REQ-028 SHALL compile in FMIN and FMAX only when macro FCMP_MINMAX_EN is defined.
REQ-029 With FCMP_MINMAX_EN defined, SHALL return the smaller (FMIN) or larger (FMAX) operand.
REQ-030 With FCMP_MINMAX_EN defined, SHALL return the other operand if exactly one is NaN, and canonical NaN 0x7FC00000 if both are NaN.
REQ-031 With FCMP_MINMAX_EN defined, SHALL return -0 for FMIN(+0,-0) and +0 for FMAX(+0,-0).
REQ-032 Without FCMP_MINMAX_EN, SHALL treat the FMIN and FMAX codes as unsupported per REQ-024.

Structure
REQ-033 SHALL take the FUNC3 codes (FEQ, FLT, FLE, FMIN, FMAX), LEN_WORD, LEN_FUNC3 and the canonical-NaN constant from the shared include; none are local.
REQ-034 SHALL place the combinational compare (eq, lt, NaN detect) in sub-module fcmp_core, instantiated between S1 and S2.

Verification
REQ-035 SHALL verify: FLT rs1=0x3F800000 (1.0), rs2=0x40000000 (2.0) -> result 1 exactly 2 cycles later, tag preserved.
REQ-036 SHALL verify: FEQ 0x00000000 vs 0x80000000 -> 1; FLT 0x80000000 vs 0x00000000 -> 0; FLE same operands -> 1.
REQ-037 SHALL verify: FLT/FEQ/FLE with rs1=0x7FC00000 -> result 0 for all three; FLT 0xC0000000 (-2.0) vs 0xBF800000 (-1.0) -> 1.
REQ-038 SHALL verify: 4 back-to-back requests with out_ready low 3 cycles -> in_ready drops after 2 accepted, all 4 results in order, none lost or duplicated.
REQ-039 SHALL verify: rstn pulsed low with both stages full -> out_valid 0 immediately, no stale result after release.
REQ-040 SHALL verify with FCMP_MINMAX_EN: FMIN 0x7FC00000 vs 0x3F800000 -> 0x3F800000; FMAX +0 vs -0 -> 0x00000000; without the macro FMIN -> illegal 1, result 0.

Source files
------------

// File: rtl/fcmp_unit_pkg.sv
// Shared constants and types for the single-precision compare unit.
// Function codes, word widths and the canonical NaN used by FMIN/FMAX live here.
package fcmp_unit_pkg;

  localparam int unsigned LEN_WORD  = 32;
  localparam int unsigned LEN_FUNC3 = 3;
  localparam int unsigned LEN_EXP   = 8;
  localparam int unsigned LEN_MAN   = 23;

  localparam logic [LEN_FUNC3-1:0] FUNC3_FLE  = 3'b000;
  localparam logic [LEN_FUNC3-1:0] FUNC3_FLT  = 3'b001;
  localparam logic [LEN_FUNC3-1:0] FUNC3_FEQ  = 3'b010;
  localparam logic [LEN_FUNC3-1:0] FUNC3_FMIN = 3'b100;
  localparam logic [LEN_FUNC3-1:0] FUNC3_FMAX = 3'b101;

  localparam logic [LEN_WORD-1:0] CANON_NAN = 32'h7FC0_0000;

  // Accepted request held in S1 (the tag is parameterised and kept alongside).
  typedef struct packed {
    logic [LEN_FUNC3-1:0] func3;
    logic [LEN_WORD-1:0]  rs1;
    logic [LEN_WORD-1:0]  rs2;
  } fcmp_req_t;

  // Relation flags produced by the combinational compare core.
  typedef struct packed {
    logic eq;
    logic lt;
    logic a_nan;
    logic b_nan;
    logic both_zero;
  } fcmp_flags_t;

  function automatic logic is_nan(input logic [LEN_WORD-1:0] x);
    return (x[LEN_WORD-2 -: LEN_EXP] == {LEN_EXP{1'b1}}) && (x[LEN_MAN-1:0] != '0);
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational single-precision relation core: equality, less-than and NaN detect.
// Signed zeros compare equal; any NaN forces eq and lt low.
module fcmp_core
  import fcmp_unit_pkg::*;
(
  input  logic [LEN_WORD-1:0] a_i,
  input  logic [LEN_WORD-1:0] b_i,
  output fcmp_flags_t         flags_o
);

  logic                a_nan_c;
  logic                b_nan_c;
  logic                any_nan_c;
  logic                both_zero_c;
  logic                a_sign_c;
  logic                b_sign_c;
  logic [LEN_WORD-2:0] a_mag_c;
  logic [LEN_WORD-2:0] b_mag_c;
  logic                lt_c;

  assign a_nan_c     = is_nan(a_i);
  assign b_nan_c     = is_nan(b_i);
  assign any_nan_c   = a_nan_c || b_nan_c;
  assign a_sign_c    = a_i[LEN_WORD-1];
  assign b_sign_c    = b_i[LEN_WORD-1];
  assign a_mag_c     = a_i[LEN_WORD-2:0];
  assign b_mag_c     = b_i[LEN_WORD-2:0];
  assign both_zero_c = (a_mag_c == '0) && (b_mag_c == '0);

  // Exponent-over-mantissa magnitude is an unsigned compare; negatives invert it.
  always_comb begin
    lt_c = 1'b0;
    if (any_nan_c || both_zero_c) begin
      lt_c = 1'b0;
    end else if (a_sign_c != b_sign_c) begin
      lt_c = a_sign_c;
    end else if (a_sign_c) begin
      lt_c = a_mag_c > b_mag_c;
    end else begin
      lt_c = a_mag_c < b_mag_c;
    end
  end

  always_comb begin
    flags_o           = '0;
    flags_o.eq        = !any_nan_c && ((a_i == b_i) || both_zero_c);
    flags_o.lt        = lt_c;
    flags_o.a_nan     = a_nan_c;
    flags_o.b_nan     = b_nan_c;
    flags_o.both_zero = both_zero_c;
  end

endmodule

// File: rtl/fcmp_unit.sv
// Two-stage pipelined FEQ/FLT/FLE unit with valid/ready handshakes on both sides.
// Define FCMP_MINMAX_EN to add FMIN/FMAX; otherwise those codes report illegal.
module fcmp_unit
  import fcmp_unit_pkg::*;
#(
  parameter int unsigned LEN_TAG = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LEN_FUNC3-1:0] func3,
  input  logic [LEN_WORD-1:0]  rs1,
  input  logic [LEN_WORD-1:0]  rs2,
  input  logic [LEN_TAG-1:0]   tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LEN_WORD-1:0]  result,
  output logic [LEN_TAG-1:0]   tag_out,
  output logic                 illegal
);

  logic                s1_valid_q, s1_valid_d;
  fcmp_req_t           s1_req_q, s1_req_d;
  logic [LEN_TAG-1:0]  s1_tag_q, s1_tag_d;

  logic                s2_valid_q, s2_valid_d;
  logic [LEN_WORD-1:0] s2_result_q, s2_result_d;
  logic [LEN_TAG-1:0]  s2_tag_q, s2_tag_d;
  logic                s2_illegal_q, s2_illegal_d;

  logic                s2_en_c;
  fcmp_flags_t         flags_c;
  logic [LEN_WORD-1:0] res_c;
  logic                illegal_c;

  // S2 may load when empty or draining; S1 may load when empty or advancing.
  assign s2_en_c  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_en_c;

  fcmp_core u_core (
    .a_i     (s1_req_q.rs1),
    .b_i     (s1_req_q.rs2),
    .flags_o (flags_c)
  );

  always_comb begin
    res_c     = '0;
    illegal_c = 1'b0;
    case (s1_req_q.func3)
      FUNC3_FEQ: res_c = LEN_WORD'(flags_c.eq);
      FUNC3_FLT: res_c = LEN_WORD'(flags_c.lt);
      FUNC3_FLE: res_c = LEN_WORD'(flags_c.lt || flags_c.eq);
`ifdef FCMP_MINMAX_EN
      FUNC3_FMIN: begin
        if (flags_c.a_nan && flags_c.b_nan)  res_c = CANON_NAN;
        else if (flags_c.a_nan)              res_c = s1_req_q.rs2;
        else if (flags_c.b_nan)              res_c = s1_req_q.rs1;
        else if (flags_c.both_zero)          res_c = s1_req_q.rs1[LEN_WORD-1] ? s1_req_q.rs1 : s1_req_q.rs2;
        else                                 res_c = flags_c.lt ? s1_req_q.rs1 : s1_req_q.rs2;
      end
      FUNC3_FMAX: begin
        if (flags_c.a_nan && flags_c.b_nan)  res_c = CANON_NAN;
        else if (flags_c.a_nan)              res_c = s1_req_q.rs2;
        else if (flags_c.b_nan)              res_c = s1_req_q.rs1;
        else if (flags_c.both_zero)          res_c = s1_req_q.rs1[LEN_WORD-1] ? s1_req_q.rs2 : s1_req_q.rs1;
        else                                 res_c = flags_c.lt ? s1_req_q.rs2 : s1_req_q.rs1;
      end
`endif
      default: begin
        res_c     = '0;
        illegal_c = 1'b1;
      end
    endcase
  end

`ifndef FCMP_MINMAX_EN
  logic unused_flags_c;
  assign unused_flags_c = ^{flags_c.a_nan, flags_c.b_nan, flags_c.both_zero};
`endif

  // Next-state for both pipeline stages; each holds when not enabled.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_req_d     = s1_req_q;
    s1_tag_d     = s1_tag_q;
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_tag_d     = s2_tag_q;
    s2_illegal_d = s2_illegal_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_req_d.func3 = func3;
        s1_req_d.rs1   = rs1;
        s1_req_d.rs2   = rs2;
        s1_tag_d       = tag_in;
      end
    end

    if (s2_en_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d  = res_c;
        s2_tag_d     = s1_tag_q;
        s2_illegal_d = illegal_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q   <= 1'b0;
      s1_req_q     <= '0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_tag_q     <= '0;
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_req_q     <= s1_req_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_tag_q     <= s2_tag_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_result_q;
  assign tag_out   = s2_tag_q;
  assign illegal   = s2_illegal_q;

endmodule

// File: tb/tb_fcmp_unit.sv
// Directed bench for fcmp_unit: latency, signed zero, NaN, back-pressure and reset.
// FMIN/FMAX expectations follow FCMP_MINMAX_EN.
module tb_fcmp_unit;
  import fcmp_unit_pkg::*;

  logic                 clk;
  logic                 rstn;
  logic                 in_valid;
  logic                 in_ready;
  logic [LEN_FUNC3-1:0] func3;
  logic [LEN_WORD-1:0]  rs1;
  logic [LEN_WORD-1:0]  rs2;
  logic [4:0]           tag_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [LEN_WORD-1:0]  result;
  logic [4:0]           tag_out;
  logic                 illegal;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  fcmp_unit #(.LEN_TAG(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func3     (func3),
    .rs1       (rs1),
    .rs2       (rs2),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One request with no back-pressure; result must appear exactly two edges later.
  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t,
                       input logic [31:0] exp_res, input logic exp_ill);
    func3     = f;
    rs1       = a;
    rs2       = b;
    tag_in    = t;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, " valid@1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({name, " valid@2"}, 32'(out_valid), 32'd1);
    check({name, " result"}, result, exp_res);
    check({name, " tag"}, 32'(tag_out), 32'(t));
    check({name, " illegal"}, 32'(illegal), 32'(exp_ill));
  endtask

  logic [2:0]  bp_f [4];
  logic [31:0] bp_a [4];
  logic [31:0] bp_b [4];
  logic [31:0] bp_r [4];
  int          idx_in;
  int          idx_out;
  logic        acc;

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    func3     = '0;
    rs1       = '0;
    rs2       = '0;
    tag_in    = '0;

    #3;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst tag_out", 32'(tag_out), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    do_op("flt 1<2", FUNC3_FLT, 32'h3F80_0000, 32'h4000_0000, 5'h15, 32'd1, 1'b0);
    do_op("feq +0 -0", FUNC3_FEQ, 32'h0000_0000, 32'h8000_0000, 5'h01, 32'd1, 1'b0);
    do_op("flt -0 +0", FUNC3_FLT, 32'h8000_0000, 32'h0000_0000, 5'h02, 32'd0, 1'b0);
    do_op("fle -0 +0", FUNC3_FLE, 32'h8000_0000, 32'h0000_0000, 5'h03, 32'd1, 1'b0);
    do_op("flt nan", FUNC3_FLT, 32'h7FC0_0000, 32'h3F80_0000, 5'h04, 32'd0, 1'b0);
    do_op("feq nan", FUNC3_FEQ, 32'h7FC0_0000, 32'h3F80_0000, 5'h05, 32'd0, 1'b0);
    do_op("fle nan", FUNC3_FLE, 32'h7FC0_0000, 32'h3F80_0000, 5'h06, 32'd0, 1'b0);
    do_op("feq nan self", FUNC3_FEQ, 32'h7FC0_0000, 32'h7FC0_0000, 5'h07, 32'd0, 1'b0);
    do_op("flt -2 -1", FUNC3_FLT, 32'hC000_0000, 32'hBF80_0000, 5'h08, 32'd1, 1'b0);
    do_op("flt -1 -2", FUNC3_FLT, 32'hBF80_0000, 32'hC000_0000, 5'h09, 32'd0, 1'b0);
    do_op("fle 2 1", FUNC3_FLE, 32'h4000_0000, 32'h3F80_0000, 5'h0A, 32'd0, 1'b0);
    do_op("fle 2 2", FUNC3_FLE, 32'h4000_0000, 32'h4000_0000, 5'h0B, 32'd1, 1'b0);
    do_op("flt -1 1", FUNC3_FLT, 32'hBF80_0000, 32'h3F80_0000, 5'h0C, 32'd1, 1'b0);
    do_op("bad func3", 3'b111, 32'h3F80_0000, 32'h4000_0000, 5'h0D, 32'd0, 1'b1);
`ifdef FCMP_MINMAX_EN
    do_op("fmin nan 1", FUNC3_FMIN, 32'h7FC0_0000, 32'h3F80_0000, 5'h10, 32'h3F80_0000, 1'b0);
    do_op("fmax +0 -0", FUNC3_FMAX, 32'h0000_0000, 32'h8000_0000, 5'h11, 32'h0000_0000, 1'b0);
    do_op("fmin +0 -0", FUNC3_FMIN, 32'h0000_0000, 32'h8000_0000, 5'h12, 32'h8000_0000, 1'b0);
    do_op("fmax nan nan", FUNC3_FMAX, 32'h7FC0_0000, 32'h7F80_0001, 5'h13, 32'h7FC0_0000, 1'b0);
    do_op("fmax -2 -1", FUNC3_FMAX, 32'hC000_0000, 32'hBF80_0000, 5'h14, 32'hBF80_0000, 1'b0);
`else
    do_op("fmin off", FUNC3_FMIN, 32'h7FC0_0000, 32'h3F80_0000, 5'h10, 32'd0, 1'b1);
    do_op("fmax off", FUNC3_FMAX, 32'h0000_0000, 32'h8000_0000, 5'h11, 32'd0, 1'b1);
`endif

    // Back-pressure: four requests offered back to back, consumer stalled three cycles.
    bp_f[0] = FUNC3_FLT; bp_a[0] = 32'h3F80_0000; bp_b[0] = 32'h4000_0000; bp_r[0] = 32'd1;
    bp_f[1] = FUNC3_FEQ; bp_a[1] = 32'h3F80_0000; bp_b[1] = 32'h4000_0000; bp_r[1] = 32'd0;
    bp_f[2] = FUNC3_FLE; bp_a[2] = 32'h4000_0000; bp_b[2] = 32'h4000_0000; bp_r[2] = 32'd1;
    bp_f[3] = FUNC3_FLT; bp_a[3] = 32'h4000_0000; bp_b[3] = 32'h3F80_0000; bp_r[3] = 32'd0;
    @(posedge clk); #1;
    check("bp idle", 32'(out_valid), 32'd0);
    idx_in  = 0;
    idx_out = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 3);
      in_valid  = (idx_in < 4);
      if (idx_in < 4) begin
        func3  = bp_f[idx_in];
        rs1    = bp_a[idx_in];
        rs2    = bp_b[idx_in];
        tag_in = 5'(idx_in + 20);
      end
      @(negedge clk);
      if (c < 2) check($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd1);
      if (c == 2) check("bp in_ready drop", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (idx_out < 4) begin
          check($sformatf("bp tag %0d", idx_out), 32'(tag_out), 32'(idx_out + 20));
          check($sformatf("bp result %0d", idx_out), result, bp_r[idx_out]);
        end
        idx_out++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx_in++;
    end
    in_valid = 1'b0;
    check("bp accepted", 32'(idx_in), 32'd4);
    check("bp drained", 32'(idx_out), 32'd4);

    // Reset with both stages occupied must drop everything at once.
    out_ready = 1'b0;
    func3 = FUNC3_FLT; rs1 = 32'h3F80_0000; rs2 = 32'h4000_0000; tag_in = 5'h1E;
    in_valid = 1'b1;
    @(posedge clk); #1;
    tag_in = 5'h1F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full out_valid", 32'(out_valid), 32'd1);
    check("full in_ready", 32'(in_ready), 32'd0);
    #1 rstn = 1'b0;
    #1;
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst result", result, 32'd0);
    check("mid rst tag", 32'(tag_out), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    #2 rstn = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post rst stale c%0d", c), 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
